// File: rtl/risc_mem_responder.sv
// Data-memory responder for the RISC core: services req/ready reads and writes with
// WAIT_CYCLES wait states, plus an idle-only preload port.
module risc_mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ready,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_err,
  output logic              busy,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data
);

  localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]      WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] mem [2**IDX_W];

  logic              accept, enter_resp, load_ok;
  logic              cur_we, cur_in_range;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic [IDX_W-1:0]  cur_idx;

  assign accept  = (state_q == IDLE) && mem_req && !load_en;
  assign load_ok = (state_q == IDLE) && load_en && ({1'b0, load_addr} < DEPTH_L);

  // With zero wait states RESP is entered on the accept edge itself, before the
  // request registers hold anything, so the live inputs are used from IDLE.
  assign cur_we       = (state_q == IDLE) ? mem_we    : we_q;
  assign cur_addr     = (state_q == IDLE) ? mem_addr  : addr_q;
  assign cur_wdata    = (state_q == IDLE) ? mem_wdata : wdata_q;
  assign cur_idx      = cur_addr[IDX_W-1:0];
  assign cur_in_range = {1'b0, cur_addr} < DEPTH_L;

  // NOTE: every output of a combinational block gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      mem_rdata <= '0;
      mem_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= mem_we;
        addr_q  <= mem_addr;
        wdata_q <= mem_wdata;
      end
      if (enter_resp) begin
        if (cur_in_range) begin
          mem_rdata <= cur_we ? cur_wdata : mem[cur_idx];
          mem_err   <= 1'b0;
        end else begin
          mem_rdata <= '0;
          mem_err   <= 1'b1;
        end
      end else if (state_q == RESP) begin
        mem_err <= 1'b0;
      end
    end
  end

  // NOTE: the storage array has no reset; contents are undefined until written,
  // and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (load_ok) begin
      mem[load_addr[IDX_W-1:0]] <= load_data;
    end else if (enter_resp && cur_in_range && cur_we) begin
      mem[cur_idx] <= cur_wdata;
    end
  end

  assign mem_ready = (state_q == RESP);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_risc_mem_responder.sv
// Randomised self-checking bench for risc_mem_responder: two instances
// (2 waits / 128 words and 0 waits / 256 words) against an array reference model.
module tb_risc_mem_responder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req[2], we[2], lden[2];
  logic [7:0] addr[2], wdata[2], ladr[2], ldat[2];
  logic       ready[2], err[2], busy[2];
  logic [7:0] rdata[2];

  int         checks = 0;
  int         errors = 0;
  logic [7:0] ref_mem[2][256];
  bit         ref_ok[2][256];

  always #5 clk = ~clk;

  risc_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(128), .WAIT_CYCLES(2)) u_dut_w2 (
    .clk(clk), .rst_n(rst_n), .mem_req(req[0]), .mem_we(we[0]), .mem_addr(addr[0]),
    .mem_wdata(wdata[0]), .mem_ready(ready[0]), .mem_rdata(rdata[0]), .mem_err(err[0]),
    .busy(busy[0]), .load_en(lden[0]), .load_addr(ladr[0]), .load_data(ldat[0]));

  risc_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .rst_n(rst_n), .mem_req(req[1]), .mem_we(we[1]), .mem_addr(addr[1]),
    .mem_wdata(wdata[1]), .mem_ready(ready[1]), .mem_rdata(rdata[1]), .mem_err(err[1]),
    .busy(busy[1]), .load_en(lden[1]), .load_addr(ladr[1]), .load_data(ldat[1]));

  function automatic int depth_of(int d);
    return (d == 0) ? 128 : 256;
  endfunction

  function automatic int waits_of(int d);
    return (d == 0) ? 2 : 0;
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic load(int d, logic [7:0] a, logic [7:0] dt);
    lden[d] = 1'b1;
    ladr[d] = a;
    ldat[d] = dt;
    @(negedge clk);
    lden[d] = 1'b0;
    if (int'(a) < depth_of(d)) begin
      ref_mem[d][a] = dt;
      ref_ok[d][a]  = 1'b1;
    end
  endtask

  // Counts negedges from the call until mem_ready and checks the response.
  task automatic wait_resp(int d, int exp_n, bit chk_data, logic [7:0] exp_d, bit exp_e, bit keep);
    int n = 0;
    bit got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (ready[d] === 1'b1) got = 1'b1;
    end
    if (!got) begin
      check("resp_timeout", 32'd0, 32'd1);
      req[d] = 1'b0;
      return;
    end
    check("latency", n, exp_n);
    check("busy_in_resp", busy[d], 1'b1);
    if (chk_data) check("rdata", rdata[d], exp_d);
    check("err", err[d], exp_e);
    if (!keep) begin
      req[d] = 1'b0;
      @(negedge clk);
      check("ready_one_cycle", ready[d], 1'b0);
    end
  endtask

  // b2b: request was left high from the previous response, so acceptance
  // happens in the next cycle rather than the current one.
  task automatic txn(int d, bit w, logic [7:0] a, logic [7:0] wd, bit keep, bit b2b);
    bit         oor = int'(a) >= depth_of(d);
    bit         known;
    logic [7:0] exp_d;
    if (oor) begin
      exp_d = 8'h00;
      known = 1'b1;
    end else if (w) begin
      exp_d = wd;
      known = 1'b1;
      ref_mem[d][a] = wd;
      ref_ok[d][a]  = 1'b1;
    end else begin
      exp_d = ref_mem[d][a];
      known = ref_ok[d][a];
    end
    req[d]   = 1'b1;
    we[d]    = w;
    addr[d]  = a;
    wdata[d] = wd;
    wait_resp(d, waits_of(d) + 1 + (b2b ? 1 : 0), known, exp_d, oor, keep);
  endtask

  function automatic logic [7:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return 8'($urandom_range(0, 255));
    return 8'($urandom_range(0, 15));
  endfunction

  initial begin
    bit quiet;
    for (int d = 0; d < 2; d++) begin
      req[d] = 0; we[d] = 0; lden[d] = 0;
      addr[d] = 0; wdata[d] = 0; ladr[d] = 0; ldat[d] = 0;
      for (int i = 0; i < 256; i++) ref_ok[d][i] = 1'b0;
    end

    #3;
    for (int d = 0; d < 2; d++) begin
      check("rst_ready", ready[d], 1'b0);
      check("rst_rdata", rdata[d], 8'h00);
      check("rst_err", err[d], 1'b0);
      check("rst_busy", busy[d], 1'b0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Load then read with two wait states.
    load(0, 8'h10, 8'hA5);
    txn(0, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0);

    // Write then read back-to-back with the request held.
    txn(0, 1'b1, 8'h20, 8'h3C, 1'b1, 1'b0);
    txn(0, 1'b0, 8'h20, 8'h00, 1'b0, 1'b1);

    // Zero wait states, continuous reads.
    load(1, 8'h00, 8'h11);
    load(1, 8'h01, 8'h22);
    load(1, 8'h02, 8'h33);
    load(1, 8'h03, 8'h44);
    txn(1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    txn(1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b1);
    txn(1, 1'b0, 8'h02, 8'h00, 1'b1, 1'b1);
    txn(1, 1'b0, 8'h03, 8'h00, 1'b0, 1'b1);

    // Out-of-range accesses and load on the 128-word instance.
    txn(0, 1'b0, 8'h80, 8'h00, 1'b0, 1'b0);
    txn(0, 1'b1, 8'h90, 8'hFF, 1'b0, 1'b0);
    load(0, 8'h90, 8'hEE);
    txn(0, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0);
    txn(0, 1'b0, 8'h90, 8'h00, 1'b0, 1'b0);

    // Reset during the WAIT of a write; the write must not commit.
    load(0, 8'h30, 8'h11);
    txn(0, 1'b0, 8'h30, 8'h00, 1'b0, 1'b0);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 8'h30; wdata[0] = 8'h5A;
    @(negedge clk);
    req[0] = 1'b0;
    check("busy_in_wait", busy[0], 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_ready", ready[0], 1'b0);
    check("async_rst_rdata", rdata[0], 8'h00);
    check("async_rst_err", err[0], 1'b0);
    check("async_rst_busy", busy[0], 1'b0);
    quiet = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (ready[0] !== 1'b0) quiet = 1'b0;
    end
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (ready[0] !== 1'b0) quiet = 1'b0;
    end
    check("no_ready_after_abort", quiet, 1'b1);
    txn(0, 1'b0, 8'h30, 8'h00, 1'b0, 1'b0);

    // Load and request in the same IDLE cycle: load wins, request accepted next.
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 8'h40;
    lden[0] = 1'b1; ladr[0] = 8'h40; ldat[0] = 8'h77;
    @(negedge clk);
    lden[0] = 1'b0;
    ref_mem[0][8'h40] = 8'h77;
    ref_ok[0][8'h40]  = 1'b1;
    check("collide_not_accepted", busy[0], 1'b0);
    wait_resp(0, waits_of(0) + 1, 1'b1, 8'h77, 1'b0, 1'b0);

    // Randomised mix of loads, reads and writes, with random back-to-back holds.
    for (int d = 0; d < 2; d++) begin
      bit held = 1'b0;
      repeat (80) begin
        if (!held && $urandom_range(0, 3) == 0) begin
          load(d, rand_addr(), 8'($urandom));
        end else begin
          bit keep = 1'($urandom_range(0, 1));
          txn(d, 1'($urandom_range(0, 1)), rand_addr(), 8'($urandom), keep, held);
          held = keep;
        end
      end
      if (held) txn(d, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
